uart_tx_fifo: RTL and testbench

Parametrised next-generation UART transmitter. Supports configurable data width, runtime parity mode and 1 or 2 stop bits. A small input FIFO with valid/ready handshake lets the upstream logic queue bytes while a frame is in flight. Frames go out back-to-back with no idle gap while the FIFO holds data. It replaces the fixed 8N1 transmitter in the serial I/O path.

---
 rtl/uart_tx_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small input FIFO, runtime parity and 1/2 stop bits.
// Optional line-break support is compiled in with `define UART_TX_BREAK_EN.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
`ifdef UART_TX_BREAK_EN
    input  logic                          tx_break,
`endif
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(DATA_BITS);
    localparam int PTR_W        = $clog2(FIFO_DEPTH);
    localparam int FCNT_W       = PTR_W + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]     baud_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 par_en;
    logic                 par_bit;
    logic                 stop2_lat;
    logic                 push;
    logic                 load;
    logic                 bit_end;
    logic                 last_data;
    logic                 last_stop;
    logic                 shift_en;
    logic                 idle_ok;
    logic                 stop_ok;

    function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic [1:0] mode);
        return (mode == 2'b01) ? ~(^d) : (^d);
    endfunction

    assign s_ready   = (fifo_count != FCNT_W'(FIFO_DEPTH));
    assign push      = s_valid && s_ready;
    assign bit_end   = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    assign last_data = (bit_idx == IDX_W'(DATA_BITS - 1));
    assign last_stop = (bit_idx == IDX_W'(stop2_lat));

`ifdef UART_TX_BREAK_EN
    logic brk_recover;
    // After a break the line must sit idle-high for a full bit period before loading.
    assign idle_ok = !tx_break && !brk_recover;
    assign stop_ok = !tx_break;
`else
    assign idle_ok = 1'b1;
    assign stop_ok = 1'b1;
`endif

    // A load happens from IDLE or straight out of the final stop bit (no idle gap).
    assign load = (fifo_count != '0) &&
                  ((state == IDLE && idle_ok) ||
                   (state == STOP && bit_end && last_stop && stop_ok));

    assign shift_en = bit_end && (state == START || (state == DATA && !last_data));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (load) rd_ptr <= rd_ptr + 1'b1;
            case ({push, load})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    // Frame datapath: word and its line options are captured together at load time.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg     <= mem[rd_ptr];
            par_bit   <= parity_bit(mem[rd_ptr], cfg_parity);
            par_en    <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            stop2_lat <= cfg_stop2;
        end else if (shift_en) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_recover <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    tx_busy  <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
`ifdef UART_TX_BREAK_EN
                    if (tx_break) begin
                        tx          <= 1'b0;
                        brk_recover <= 1'b1;
                    end else if (brk_recover) begin
                        if (bit_end) brk_recover <= 1'b0;
                        else         baud_cnt    <= baud_cnt + 1'b1;
                    end
`endif
                    if (load) begin
                        state   <= START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shreg[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (last_data) begin
                            bit_idx <= '0;
                            if (par_en) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state    <= STOP;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!last_stop) begin
                            bit_idx <= bit_idx + 1'b1;
                        end else begin
                            bit_idx <= '0;
                            if (load) begin
                                state <= START;
                                tx    <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                tx_busy <= 1'b0;
                                tx      <= 1'b1;
                            end
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line monitor compares every tx cycle
// against frames queued at push time; per-scenario tasks add timing checks.
module tb_uart_tx_fifo;

    localparam int CLKS = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic [1:0] cfg_parity = 2'b00;
    logic       cfg_stop2 = 1'b0;
    logic       s_ready;
    logic       tx;
    logic       tx_busy;
    logic [2:0] fifo_count;
    logic       s_valid7 = 1'b0;
    logic [6:0] s_data7 = 7'h00;
    logic       s_ready7;
    logic       tx7;
    logic       tx_busy7;
    logic [2:0] fifo_count7;
`ifdef UART_TX_BREAK_EN
    logic       tx_break = 1'b0;
`endif

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
`ifdef UART_TX_BREAK_EN
        .tx_break(tx_break),
`endif
        .tx(tx), .tx_busy(tx_busy), .fifo_count(fifo_count)
    );

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .FIFO_DEPTH(4)) dut7 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid7), .s_ready(s_ready7), .s_data(s_data7),
        .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
`ifdef UART_TX_BREAK_EN
        .tx_break(1'b0),
`endif
        .tx(tx7), .tx_busy(tx_busy7), .fifo_count(fifo_count7)
    );

    typedef struct packed {
        logic [15:0] bits;
        int          n;
    } frame_t;

    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    frame_t exp_q[$];
    int     start_q[$];
    frame_t cur;
    bit     mon_active = 1'b0;
    int     mon_pos = 0;
    int     frames_done = 0;
    int     fail_prints = 0;
    bit     watch_en = 1'b0;
    int     max_count = 0;
    int     ready_bad = 0;
    bit     saw_full = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic frame_t make_frame(input logic [8:0] d, input int dbits,
                                          input logic [1:0] par, input logic stop2);
        frame_t f;
        logic   p;
        f = '0;
        p = 1'b0;
        f.bits[f.n] = 1'b0;
        f.n++;
        for (int i = 0; i < dbits; i++) begin
            f.bits[f.n] = d[i];
            p = p ^ d[i];
            f.n++;
        end
        if (par == 2'b01) begin
            f.bits[f.n] = ~p;
            f.n++;
        end else if (par == 2'b10) begin
            f.bits[f.n] = p;
            f.n++;
        end
        f.bits[f.n] = 1'b1;
        f.n++;
        if (stop2) begin
            f.bits[f.n] = 1'b1;
            f.n++;
        end
        return f;
    endfunction

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            if (watch_en) begin
                if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
                if (fifo_count == 3'd4) saw_full = 1'b1;
                if (s_ready !== (fifo_count != 3'd4)) ready_bad++;
            end
            if (rst_n !== 1'b1) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && tx_busy === 1'b1 && tx === 1'b0) begin
                    mon_pos    = 0;
                    mon_active = 1'b1;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame cycle=%0d got start bit, required idle", cyc);
                        cur   = '0;
                        cur.n = 1;
                    end else begin
                        cur = exp_q.pop_front();
                        start_q.push_back(cyc);
                    end
                end
                if (mon_active) begin
                    checks++;
                    if (tx !== cur.bits[mon_pos / CLKS] || tx_busy !== 1'b1) begin
                        errors++;
                        if (fail_prints < 20) begin
                            fail_prints++;
                            $display("FAIL line_bit cycle=%0d pos=%0d got tx=%b busy=%b required tx=%b busy=1",
                                     cyc, mon_pos, tx, tx_busy, cur.bits[mon_pos / CLKS]);
                        end
                    end
                    mon_pos++;
                    if (mon_pos >= cur.n * CLKS) begin
                        mon_active = 1'b0;
                        frames_done++;
                    end
                end
            end
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Caller must be at posedge+1 so s_valid never straddles an edge.
    task automatic push_word(input logic [7:0] d, input logic [1:0] par, input logic st2);
        bit done = 1'b0;
        s_data     = d;
        cfg_parity = par;
        cfg_stop2  = st2;
        s_valid    = 1'b1;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (s_ready === 1'b1) done = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL push_timeout data=%h got no s_ready, required accept", d);
        end else begin
            exp_q.push_back(make_frame({1'b0, d}, 8, par, st2));
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_start(input int n0, output int s);
        int k = 0;
        while (start_q.size() <= n0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (start_q.size() <= n0) begin
            errors++;
            $display("FAIL start_timeout got %0d starts, required %0d", start_q.size(), n0 + 1);
            s = cyc;
        end else begin
            s = start_q[n0];
        end
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (frames_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (frames_done < target) begin
            errors++;
            $display("FAIL frame_timeout got %0d frames, required %0d", frames_done, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b required 1", tx); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b required 0", tx_busy); end
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", s_ready); end
        checks++;
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d required 0", fifo_count); end
        align();
        rst_n = 1'b1;
    endtask

    task automatic test_8n1();
        logic [9:0] line;
        int n0;
        int fd;
        int s;
        line = 10'b1101001010;
        n0 = start_q.size();
        fd = frames_done;
        align();
        push_word(8'hA5, 2'b00, 1'b0);
        wait_start(n0, s);
        for (int i = 0; i < 10; i++) begin
            wait_cyc(s + i * CLKS + 5);
            checks++;
            if (tx !== line[i]) begin
                errors++;
                $display("FAIL a5_bit%0d got %b required %b", i, tx, line[i]);
            end
        end
        wait_cyc(s + 99);
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL a5_busy_last got %b required 1", tx_busy); end
        wait_cyc(s + 100);
        checks++;
        if (tx_busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL a5_busy_fall got busy=%b tx=%b required busy=0 tx=1", tx_busy, tx);
        end
        wait_done(fd + 1, 50);
    endtask

    task automatic test_parity();
        int n0;
        int fd;
        int s;
        n0 = start_q.size();
        fd = frames_done;
        align();
        push_word(8'h01, 2'b10, 1'b1);
        wait_start(n0, s);
        wait_cyc(s + 119);
        checks++;
        if (tx_busy !== 1'b1) begin errors++; $display("FAIL even_stop2_busy got %b required 1", tx_busy); end
        wait_cyc(s + 120);
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL even_stop2_len got busy=%b required 0", tx_busy); end
        wait_done(fd + 1, 50);

        n0 = start_q.size();
        align();
        push_word(8'h03, 2'b01, 1'b0);
        wait_start(n0, s);
        wait_cyc(s + 9 * CLKS + 5);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL odd_parity_bit got %b required 1", tx); end
        wait_done(fd + 2, 150);
    endtask

    task automatic test_data7();
        frame_t f;
        int     s;
        int     k;
        f = make_frame({2'b00, 7'h7F}, 7, 2'b10, 1'b0);
        align();
        cfg_parity = 2'b10;
        cfg_stop2  = 1'b0;
        checks++;
        if (s_ready7 !== 1'b1) begin errors++; $display("FAIL d7_ready got %b required 1", s_ready7); end
        s_data7  = 7'h7F;
        s_valid7 = 1'b1;
        align();
        s_valid7 = 1'b0;
        k = 0;
        while (tx7 !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        s = cyc;
        for (int i = 0; i < 10; i++) begin
            wait_cyc(s + i * CLKS + 5);
            checks++;
            if (tx7 !== f.bits[i]) begin
                errors++;
                $display("FAIL d7_bit%0d got %b required %b", i, tx7, f.bits[i]);
            end
        end
        wait_cyc(s + 100);
        checks++;
        if (tx_busy7 !== 1'b0 || tx7 !== 1'b1 || fifo_count7 !== 3'd0) begin
            errors++;
            $display("FAIL d7_end got busy=%b tx=%b count=%0d required busy=0 tx=1 count=0",
                     tx_busy7, tx7, fifo_count7);
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        int fd;
        int d;
        n0 = start_q.size();
        fd = frames_done;
        max_count = 0;
        ready_bad = 0;
        saw_full  = 1'b0;
        align();
        watch_en = 1'b1;
        for (int i = 0; i < 6; i++) push_word(8'h11 + 8'(i), 2'b00, 1'b0);
        wait_done(fd + 6, 1000);
        watch_en = 1'b0;
        checks++;
        if (max_count != 4) begin errors++; $display("FAIL fifo_max got %0d required 4", max_count); end
        checks++;
        if (!saw_full) begin errors++; $display("FAIL fifo_full got never-full required full"); end
        checks++;
        if (ready_bad != 0) begin errors++; $display("FAIL ready_vs_count got %0d bad cycles required 0", ready_bad); end
        for (int i = 1; i < 6; i++) begin
            checks++;
            d = (start_q.size() > n0 + i) ? start_q[n0 + i] - start_q[n0 + i - 1] : -1;
            if (d != 10 * CLKS) begin
                errors++;
                $display("FAIL b2b_gap%0d got %0d cycles required %0d", i, d, 10 * CLKS);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n0;
        int fd;
        int s;
        int bad;
        n0 = start_q.size();
        align();
        push_word(8'h3C, 2'b00, 1'b0);
        push_word(8'h5A, 2'b00, 1'b0);
        wait_start(n0, s);
        wait_cyc(s + 44);
        align();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b required 1", tx); end
        checks++;
        if (tx_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b required 0", tx_busy); end
        checks++;
        if (fifo_count !== 3'd0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_fifo got count=%0d ready=%b required 0/1", fifo_count, s_ready);
        end
        exp_q.delete();
        align();
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL midrst_idle got %0d active cycles required 0", bad); end
        fd = frames_done;
        align();
        push_word(8'hC3, 2'b00, 1'b0);
        wait_done(fd + 1, 200);
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        int bad;
        int highs;
        int fd;
        fd = frames_done;
        align();
        tx_break = 1'b1;
        align();
        push_word(8'h55, 2'b00, 1'b0);
        bad = 0;
        repeat (48) begin
            @(negedge clk);
            if (tx !== 1'b0 || tx_busy !== 1'b0 || fifo_count !== 3'd1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL break_hold got %0d bad cycles required 0", bad); end
        align();
        tx_break = 1'b0;
        @(posedge clk);
        highs = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx !== 1'b1) break;
            highs++;
        end
        checks++;
        if (highs < CLKS || highs >= 100) begin
            errors++;
            $display("FAIL break_recover got %0d idle-high cycles required %0d..99", highs, CLKS);
        end
        wait_done(fd + 1, 200);
    endtask
`endif

    initial begin
        fork
            monitor_loop();
            begin
                #400000;
                errors++;
                $display("FAIL watchdog got timeout required completion");
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "watchdog");
            end
        join_none
        test_reset();
        test_8n1();
        test_parity();
        test_data7();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_frames got %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
